solver_lane_scheduler: RTL and testbench

- Sequences the multi-lane ROM solver. Walks every (range, K) division entry and dispatches each one to one of NUM_LANES solver lanes over a valid/ready job interface.
- Collects each lane's 64-bit partial sum through a round-robin result arbiter.
- Accumulates the partials into a 64-bit total using chunked 32-bit adds, then signals done.
- Sits between the top-level start/report logic and the replicated solver lanes.

---
 rtl/solver_lane_scheduler.sv | 175 +++++++++++++++++
 tb/tb_solver_lane_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solver_lane_scheduler.sv
// Walks every (range, K) division entry, dispatches each to a free solver lane,
// and folds the returned 64-bit partials into a total with two 32-bit add steps.
// Jobs are offered one at a time and held until taken; results drain round-robin.
module solver_lane_scheduler #(
  parameter int ENTRY_COUNT = 468,
  parameter int K_MAX       = 12,
  parameter int NUM_LANES   = 4,
  parameter int IDX_W       = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [63:0]               total_sum,
  output logic [NUM_LANES-1:0]      job_valid,
  input  logic [NUM_LANES-1:0]      job_ready,
  output logic [IDX_W-1:0]          job_idx,
  output logic [3:0]                job_k,
  input  logic [NUM_LANES-1:0]      res_valid,
  input  logic [64*NUM_LANES-1:0]   res_data,
  output logic [NUM_LANES-1:0]      res_ready
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0] ENTRY_END = IDX_W'(ENTRY_COUNT);
  localparam logic [3:0]       K_LAST    = 4'(K_MAX);
  localparam logic [LW-1:0]    LANE_LAST = LW'(NUM_LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {A_IDLE, A_LOW, A_HIGH} acc_state_t;

  state_t               state;
  acc_state_t           acc_state;
  logic [IDX_W-1:0]     issue_idx;
  logic [IDX_W-1:0]     retired;
  logic [3:0]           k_ctr;
  logic [LW-1:0]        rr_ptr;
  logic [63:0]          acc;
  logic [63:0]          add_reg;
  logic                 carry;

  logic                 start_go;
  logic                 acc_en;
  logic [NUM_LANES-1:0] first_rdy;
  logic [NUM_LANES-1:0] grant;
  logic [LW-1:0]        grant_lane;
  logic [LW-1:0]        lane_sel;
  logic                 found;
  logic [63:0]          sel_data;

  // A start is only honoured when no run is in progress.
  assign start_go  = start && (state == S_IDLE || state == S_DONE);
  // Lowest-numbered ready lane, isolated as a one-hot vector.
  assign first_rdy = job_ready & (~job_ready + NUM_LANES'(1));
  // Results are taken only between adds and only for jobs actually issued,
  // so stray res_valid after the last retirement is never acknowledged.
  assign acc_en    = (state == S_RUN || state == S_DRAIN) &&
                     (acc_state == A_IDLE) && (retired < issue_idx);
  assign res_ready = acc_en ? grant : '0;

  // Round-robin search for the first valid result starting at rr_ptr.
  always_comb begin
    grant      = '0;
    grant_lane = '0;
    lane_sel   = '0;
    found      = 1'b0;
    for (int o = 0; o < NUM_LANES; o++) begin
      lane_sel = LW'((int'(rr_ptr) + o) % NUM_LANES);
      if (!found && res_valid[lane_sel]) begin
        found            = 1'b1;
        grant[lane_sel]  = 1'b1;
        grant_lane       = lane_sel;
      end
    end
  end

  // Select the granted lane's 64-bit result slice.
  always_comb begin
    sel_data = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (grant[l]) sel_data = res_data[l*64 +: 64];
    end
  end

  // Run sequencing and job dispatch; an offer stays on its lane until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      total_sum <= '0;
      job_valid <= '0;
      job_idx   <= '0;
      job_k     <= '0;
      issue_idx <= '0;
      k_ctr     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            issue_idx <= '0;
            k_ctr     <= 4'd1;
            done      <= 1'b0;
            busy      <= 1'b1;
            job_valid <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (job_valid != '0) begin
            if ((job_valid & job_ready) != '0) begin
              issue_idx <= issue_idx + IDX_W'(1);
              k_ctr     <= (k_ctr == K_LAST) ? 4'd1 : k_ctr + 4'd1;
              job_valid <= '0;
            end
          end else if (issue_idx == ENTRY_END) begin
            state <= S_DRAIN;
          end else if (job_ready != '0) begin
            job_valid <= first_rdy;
            job_idx   <= issue_idx;
            job_k     <= k_ctr;
          end
        end
        S_DRAIN: begin
          if (retired == ENTRY_END && acc_state == A_IDLE) begin
            total_sum <= acc;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result capture and two-step 64-bit accumulation (low word, then high with carry).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_state <= A_IDLE;
      acc       <= '0;
      add_reg   <= '0;
      carry     <= 1'b0;
      retired   <= '0;
      rr_ptr    <= '0;
    end else if (start_go) begin
      acc_state <= A_IDLE;
      acc       <= '0;
      carry     <= 1'b0;
      retired   <= '0;
    end else begin
      case (acc_state)
        A_IDLE: begin
          if (res_ready != '0) begin
            add_reg   <= sel_data;
            rr_ptr    <= (grant_lane == LANE_LAST) ? '0 : grant_lane + LW'(1);
            retired   <= retired + IDX_W'(1);
            acc_state <= A_LOW;
          end
        end
        A_LOW: begin
          {carry, acc[31:0]} <= {1'b0, acc[31:0]} + {1'b0, add_reg[31:0]};
          acc_state          <= A_HIGH;
        end
        A_HIGH: begin
          acc[63:32] <= acc[63:32] + add_reg[63:32] + {31'b0, carry};
          acc_state  <= A_IDLE;
        end
        default: acc_state <= A_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_solver_lane_scheduler.sv
// Scoreboard bench: lane models answer jobs, a monitor checks jobs, grants and totals.
// Runs use a 24-entry table to keep every run short while covering wrap of k and carries.
module tb_solver_lane_scheduler;

  localparam int EC = 24;
  localparam int KM = 12;
  localparam int NL = 4;
  localparam int IW = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic [63:0]       total_sum;
  logic [NL-1:0]     job_valid, job_ready, res_valid, res_ready;
  logic [IW-1:0]     job_idx;
  logic [3:0]        job_k;
  logic [64*NL-1:0]  res_data;

  solver_lane_scheduler #(
    .ENTRY_COUNT(EC), .K_MAX(KM), .NUM_LANES(NL), .IDX_W(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .total_sum(total_sum), .job_valid(job_valid), .job_ready(job_ready),
    .job_idx(job_idx), .job_k(job_k), .res_valid(res_valid),
    .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard queues
  int          exp_idx[$];
  int          exp_k[$];
  logic [63:0] exp_tot[$];
  int          exp_grant[$];

  // lane model controls
  logic [NL-1:0] lane_en = '0;
  int            cap = 1;
  int            lat = 2;
  int            mode = 0;
  logic          gate = 1'b1;
  logic          hold_req = 1'b0;
  logic          model_clr = 1'b0;

  // lane model state
  logic [63:0] rmem [NL][32];
  int          rdue [NL][32];
  int          wp [NL];
  int          rp [NL];
  int          cyc = 0;
  int          hold_cnt = 0;
  logic        hold_fired = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] result_of(input int m, input int idx);
    case (m)
      0: return 64'(idx + 1);
      1: return 64'h1_0000_0001;
      2: return (idx == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ((idx == 1) ? 64'h2 : 64'h0);
      default: return 64'hC000_0000;
    endcase
  endfunction

  // Lane responder: drives job_ready/res_* at negedge, then books the handshakes
  // that the next rising edge will perform.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || model_clr) begin
      for (int l = 0; l < NL; l++) begin
        wp[l] = 0;
        rp[l] = 0;
      end
    end
    if (!hold_req) hold_fired = 1'b0;
    if (hold_cnt > 0) hold_cnt--;
    else if (hold_req && !hold_fired && job_valid[2]) begin
      hold_cnt   = 10;
      hold_fired = 1'b1;
    end
    for (int l = 0; l < NL; l++) begin
      job_ready[l] = lane_en[l] && ((wp[l] - rp[l]) < cap) && !(l == 2 && hold_cnt > 0);
      if (gate && wp[l] != rp[l] && rdue[l][rp[l] % 32] <= cyc) begin
        res_valid[l]         = 1'b1;
        res_data[l*64 +: 64] = rmem[l][rp[l] % 32];
      end else begin
        res_valid[l]         = 1'b0;
        res_data[l*64 +: 64] = '0;
      end
    end
    #1;
    if (rst_n) begin
      for (int l = 0; l < NL; l++) begin
        if (job_valid[l] && job_ready[l]) begin
          rmem[l][wp[l] % 32] = result_of(mode, int'(job_idx));
          rdue[l][wp[l] % 32] = cyc + lat;
          wp[l]++;
        end
        if (res_valid[l] && res_ready[l]) rp[l]++;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  logic [NL-1:0] xf, rg;
  logic          done_q = 1'b0;
  logic          hold_seen = 1'b0;
  int            gcount = 0;
  int            last_gcyc = 0;
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      xf = job_valid & job_ready;
      rg = res_valid & res_ready;
      if (job_valid != '0) chk("job_valid_onehot", 64'($onehot(job_valid)), 64'd1);
      if (xf != '0) begin
        if (exp_idx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL job_extra: idx %0d issued, no job expected", job_idx);
        end else begin
          chk("job_idx", 64'(job_idx), 64'(exp_idx.pop_front()));
          chk("job_k", 64'(job_k), 64'(exp_k.pop_front()));
        end
      end
      if (hold_cnt > 0) begin
        chk("hold_valid", 64'(job_valid), 64'b0100);
        chk("hold_idx", 64'(job_idx), 64'd2);
        chk("hold_k", 64'(job_k), 64'd3);
      end else if (hold_fired && !hold_seen) begin
        chk("hold_xfer", 64'(xf), 64'b0100);
        hold_seen = 1'b1;
      end
      if (rg != '0 && exp_grant.size() > 0) begin
        chk("grant_lane", 64'(rg), 64'(1) << exp_grant.pop_front());
        if (gcount > 0) chk("grant_gap", 64'(cyc - last_gcyc), 64'd3);
        last_gcyc = cyc;
        gcount++;
        if (exp_grant.size() == 0) gcount = 0;
      end
      if (done && !done_q) begin
        if (exp_tot.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_extra: done rose with total 0x%0h, none expected", total_sum);
        end else begin
          chk("total_sum", total_sum, exp_tot.pop_front());
        end
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
    if (!hold_req) hold_seen = 1'b0;
    done_q = done;
  end

  task automatic begin_run(input logic [NL-1:0] en, input int c, input int l, input int m,
                           input logic [63:0] tot, input logic g);
    @(negedge clk);
    lane_en   = en;
    cap       = c;
    lat       = l;
    mode      = m;
    gate      = g;
    model_clr = 1'b1;
    repeat (2) @(negedge clk);
    model_clr = 1'b0;
    exp_idx.delete();
    exp_k.delete();
    for (int i = 0; i < EC; i++) begin
      exp_idx.push_back(i);
      exp_k.push_back((i % KM) + 1);
    end
    exp_tot.push_back(tot);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #3;
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_after_start", 64'(done), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    #5;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, n);
      rst_n = 1'b0;
      exp_tot.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    chk("jobs_remaining", 64'(exp_idx.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset state
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_total", total_sum, 64'd0);
    chk("rst_job_valid", 64'(job_valid), 64'd0);
    chk("rst_res_ready", 64'(res_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // all lanes hold results at once: grants rotate 0,1,2,3,0,1,2,3 three cycles apart
    begin_run(4'b1111, 2, 2, 0, 64'd300, 1'b0);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) exp_grant.push_back(i % 4);
    gate = 1'b1;
    wait_done();
    chk("grants_remaining", 64'(exp_grant.size()), 64'd0);

    // single lane, results idx+1, with a start pulsed mid-run that must be ignored
    begin_run(4'b0001, 16, 2, 0, 64'd300, 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #3;
    chk("busy_after_mid_start", 64'(busy), 64'd1);
    wait_done();

    // constant partials, 24 * 0x1_0000_0001
    begin_run(4'b1111, 4, 3, 1, 64'h18_0000_0018, 1'b1);
    wait_done();

    // low-word carries: 24 * 0xC000_0000
    begin_run(4'b1111, 4, 3, 3, 64'h12_0000_0000, 1'b1);
    wait_done();

    // modulo 2^64 wrap: all-ones + 2
    begin_run(4'b1111, 4, 2, 2, 64'h1, 1'b1);
    wait_done();

    // lane 2 stalls its offered job for 10 cycles
    hold_req = 1'b1;
    begin_run(4'b1111, 1, 30, 0, 64'd300, 1'b1);
    wait_done();
    hold_req = 1'b0;

    // asynchronous reset during DRAIN, then a clean run
    begin_run(4'b1111, 8, 2, 0, 64'd300, 1'b0);
    n = 0;
    while (exp_idx.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("drain_busy", 64'(busy), 64'd1);
    gate = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_total", total_sum, 64'd0);
    chk("arst_job_valid", 64'(job_valid), 64'd0);
    chk("arst_res_ready", 64'(res_ready), 64'd0);
    exp_tot.delete();
    exp_idx.delete();
    exp_k.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    begin_run(4'b1111, 4, 3, 0, 64'd300, 1'b1);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
